// File: rtl/pe_eject_buffer.sv
// pe_eject_buffer
//   Ejection stage between a mesh switch's local output port and the PE
//   interface receive side. Each incoming flit's destination is compared with
//   this node's (X,Y). Misrouted flits are handshaken and discarded, and they
//   are counted. Correctly addressed flits go into a DEPTH-entry
//   first-word-fall-through FIFO.
//
// Ports
//   clk        : single clock, rising edge
//   rstn       : synchronous active-low reset
//   i_data     : flit from switch; dest_x = [XW-1:0], dest_y = [XW+YW-1:XW]
//   i_valid    : switch flit valid
//   o_ready    : buffer can accept a flit (registered state only)
//   o_data     : head flit to PE interface (mem[rd_ptr])
//   o_valid    : o_data valid (FIFO not empty)
//   i_ready    : PE interface accepts the head flit
//   o_count    : stored flit count, 0..DEPTH
//   o_drop_cnt : misrouted flits discarded, saturating at 16'hFFFF
//   o_drop_err : sticky, set on the first discard

module pe_eject_buffer #(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int total_width = 280,
    parameter int x_size      = 4,
    parameter int y_size      = 4,
    parameter int DEPTH       = 4,
    localparam int XW = (x_size > 1) ? $clog2(x_size) : 1,
    localparam int YW = (y_size > 1) ? $clog2(y_size) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [total_width-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AW:0]            o_count,
    output logic [15:0]            o_drop_cnt,
    output logic                   o_drop_err
);

    localparam logic [XW-1:0] X_ID  = XW'(X);
    localparam logic [YW-1:0] Y_ID  = YW'(Y);
    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [total_width-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          drop_err_q, drop_err_d;

    logic match;
    logic accept;
    logic push_store;
    logic push_drop;
    logic pop;

    // Handshake flags depend only on registered occupancy, never on
    // i_valid/i_ready, so there is no combinational loop through the switch.
    assign o_ready = (count_q != FULL);
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];

    assign o_count    = count_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_drop_err = drop_err_q;

    assign match      = (i_data[XW-1:0] == X_ID) & (i_data[XW+YW-1:XW] == Y_ID);
    assign accept     = i_valid & o_ready;
    assign push_store = accept & match;
    assign push_drop  = accept & ~match;
    assign pop        = o_valid & i_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        drop_err_d = drop_err_q;

        if (push_store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;

        // A discarded push never touches occupancy, so it falls into the
        // pop-only branch when it coincides with a pop.
        unique case ({push_store, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push_drop) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage carries data only; stale contents are masked by o_valid.
    always_ff @(posedge clk) begin
        if (rstn && push_store) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: tb/tb_pe_eject_buffer.sv
module tb_pe_eject_buffer;

    localparam int W  = 280;
    localparam int D  = 4;
    localparam int TX = 1;
    localparam int TY = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          i_ready;
    logic [2:0]    o_count;
    logic [15:0]   o_drop_cnt;
    logic          o_drop_err;

    pe_eject_buffer #(
        .X(TX), .Y(TY), .total_width(W), .x_size(4), .y_size(4), .DEPTH(D)
    ) dut (
        .clk(clk), .rstn(rstn), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_drop_cnt(o_drop_cnt),
        .o_drop_err(o_drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input int dx, input int dy);
        logic [287:0] t;
        logic [W-1:0] f;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        f = t[W-1:0];
        f[1:0] = dx[1:0];
        f[3:2] = dy[1:0];
        return f;
    endfunction

    // Reference model: a queue of stored flits plus drop bookkeeping.
    logic [W-1:0] mq[$];
    int           m_drop = 0;
    bit           m_err  = 0;
    bit           started = 0;

    always @(posedge clk) begin
        bit acc, pp;
        if (!rstn) begin
            mq.delete();
            m_drop = 0;
            m_err  = 0;
        end else begin
            pp  = i_ready && (mq.size() != 0);
            acc = i_valid && (mq.size() != D);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                if (i_data[1:0] == TX[1:0] && i_data[3:2] == TY[1:0]) mq.push_back(i_data);
                else begin
                    if (m_drop < 16'hFFFF) m_drop++;
                    m_err = 1;
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("count", W'(o_count), W'(mq.size()));
            chk("valid", W'(o_valid), W'(mq.size() != 0));
            chk("ready", W'(o_ready), W'(mq.size() != D));
            chk("drop_cnt", W'(o_drop_cnt), W'(m_drop));
            chk("drop_err", W'(o_drop_err), W'(m_err));
            if (mq.size() != 0) chk("data", o_data, mq[0]);
        end
    end

    // Called just after a negedge; returns just after the negedge that
    // follows the accepting clock edge, with i_valid dropped.
    task automatic send(input logic [W-1:0] f);
        int t = 0;
        i_data  = f;
        i_valid = 1'b1;
        while (!o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] f;
        rstn    = 1'b0;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = mk(TX, TY);

        // Reset with a valid flit offered: nothing may be stored.
        repeat (3) @(negedge clk);
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_ready", W'(o_ready), W'(1));
        chk("rst_count", W'(o_count), W'(0));
        chk("rst_drop", W'(o_drop_cnt), W'(0));
        chk("rst_err", W'(o_drop_err), W'(0));
        rstn    = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);

        // Single flit: visible one cycle after acceptance.
        i_ready = 1'b1;
        f = {8'hA5, 268'd0, 4'b1001};
        send(f);
        chk("single_valid", W'(o_valid), W'(1));
        chk("single_data", o_data, {8'hA5, 268'd0, 4'b1001});
        @(negedge clk);
        chk("single_count", W'(o_count), W'(0));

        // Fill under backpressure, then drain with D4/D5 entering as space frees.
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(mk(TX, TY));
        i_data  = mk(TX, TY);
        i_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("full_count", W'(o_count), W'(4));
        chk("full_ready", W'(o_ready), W'(0));
        i_ready = 1'b1;
        send(i_data);
        send(mk(TX, TY));
        repeat (6) @(negedge clk);
        chk("fill_drained", W'(o_count), W'(0));

        // Continuous stream: occupancy holds at one while pointers wrap.
        for (int i = 0; i < 20; i++) begin
            send(mk(TX, TY));
            if (i > 0) chk("stream_count", W'(o_count), W'(1));
        end
        @(negedge clk);

        // Misroutes are handshaken and discarded.
        i_ready = 1'b0;
        send(mk(0, 2));
        send(mk(1, 3));
        send(mk(1, 2));
        chk("mis_drop", W'(o_drop_cnt), W'(2));
        chk("mis_err", W'(o_drop_err), W'(1));
        chk("mis_count", W'(o_count), W'(1));
        i_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Drop counter saturation.
        #2;
        force dut.drop_cnt_q = 16'hFFFE;
        m_drop = 16'hFFFE;
        @(negedge clk);
        #2;
        release dut.drop_cnt_q;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(mk(3, 0));
        chk("sat_drop", W'(o_drop_cnt), W'(16'hFFFF));

        // Mid-run reset with two flits buffered.
        i_ready = 1'b0;
        send(mk(TX, TY));
        send(mk(TX, TY));
        chk("pre_rst_count", W'(o_count), W'(2));
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", W'(o_count), W'(0));
        chk("mid_rst_valid", W'(o_valid), W'(0));
        chk("mid_rst_err", W'(o_drop_err), W'(0));
        rstn = 1'b1;

        // Randomized traffic with mostly matching destinations.
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) i_data = mk(TX, TY);
            else i_data = mk($urandom_range(0, 3), $urandom_range(0, 3));
            i_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (D + 2) @(negedge clk);
        chk("final_empty", W'(o_count), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
